// File: rtl/key_schedule_stream_pkg.sv
// Shared AES-128 definitions for the key schedule: key types, round constants
// and the forward S-box.
package key_schedule_stream_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;

  typedef logic [127:0] key_t;
  typedef logic [127:0] roundKey_t;

  // Indexed by round number; entry 0 is unused, entries 11..15 pad to a 4-bit index.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/key_schedule_stream_step.sv
// One AES-128 key-expansion step: derives the next round key from the previous one.
module key_expand_step
  import key_schedule_stream_pkg::*;
(
  input  roundKey_t  prev,
  input  logic [7:0] rcon,
  output roundKey_t  next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev;

  // RotWord folded into the byte order fed to the S-boxes.
  assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_stream.sv
// Iterative AES-128 key expansion into an 11-entry register file, streamed
// forward or reverse over valid/ready and cached for replay.
module key_schedule_stream
  import key_schedule_stream_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_valid,
  output logic       key_ready,
  input  key_t       key_in,
  input  logic       decrypt,
  input  logic       replay_valid,
  output logic       rk_valid,
  input  logic       rk_ready,
  output roundKey_t  rk_out,
  output logic [3:0] rk_index,
  output logic       rk_last,
  output logic       cached
);

  if (NUM_ROUNDS != AES_NUM_ROUNDS) begin : g_bad_rounds
    $error("key_schedule_stream: only NUM_ROUNDS=10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

  state_t     state;
  roundKey_t  rf [0:NUM_ROUNDS];
  logic [3:0] cnt;
  logic [3:0] ptr;
  logic       dir;
  roundKey_t  step_prev;
  roundKey_t  step_next;

  assign step_prev = rf[cnt - 4'd1];

  key_expand_step u_step (
    .prev (step_prev),
    .rcon (RCON[cnt]),
    .next (step_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      dir    <= 1'b0;
      cached <= 1'b0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (key_valid) begin
            rf[0]  <= key_in;
            dir    <= decrypt;
            ptr    <= decrypt ? LAST : '0;
            cached <= 1'b0;
            cnt    <= 4'd1;
            state  <= EXPAND;
          end else if (replay_valid && cached) begin
            dir   <= decrypt;
            ptr   <= decrypt ? LAST : '0;
            state <= STREAM;
          end
        end
        EXPAND: begin
          rf[cnt] <= step_next;
          cnt     <= cnt + 4'd1;
          if (cnt == LAST) begin
            cached <= 1'b1;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (rk_ready) begin
            if (rk_last)  state <= IDLE;
            else if (dir) ptr   <= ptr - 4'd1;
            else          ptr   <= ptr + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state only; rk_ready never reaches rk_valid.
  assign key_ready = (state == IDLE);
  assign rk_valid  = (state == STREAM);
  assign rk_out    = rf[ptr];
  assign rk_index  = ptr;
  assign rk_last   = rk_valid && (ptr == (dir ? 4'd0 : LAST));

endmodule

// File: tb/tb_key_schedule_stream.sv
// Directed bench for key_schedule_stream with an independent AES key-expansion model.
module tb_key_schedule_stream;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         decrypt = 1'b0;
  logic         replay_valid = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ready, rk_valid, rk_last, cached;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         last;
  } exp_t;

  exp_t         q[$];
  logic [7:0]   sb [256];
  logic [127:0] sched [11];

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  key_schedule_stream #(.NUM_ROUNDS(10)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .replay_valid (replay_valid),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .rk_out       (rk_out),
    .rk_index     (rk_index),
    .rk_last      (rk_last),
    .cached       (cached)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---- reference model: GF(2^8) arithmetic, S-box by inversion + affine map
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int x = 1; x < 256; x++) if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_stream(input logic dec);
    for (int n = 0; n < 11; n++) begin
      int r;
      r = dec ? 10 - n : n;
      q.push_back('{idx: 4'(r), key: sched[r], last: (n == 10)});
    end
  endtask

  // ---- per-cycle scoreboard compare
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && rk_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rk_valid", rk_valid, 1'b0);
        end else begin
          chk("stream_idx", rk_index, q[0].idx);
          chk("stream_key", rk_out, q[0].key);
          chk("stream_last", rk_last, q[0].last);
          if (rk_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---- stimulus helpers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_key_ready"}, key_ready, 1'b1);
    chk({tag, "_rk_valid"}, rk_valid, 1'b0);
    chk({tag, "_rk_last"}, rk_last, 1'b0);
    chk({tag, "_rk_index"}, rk_index, 4'd0);
    chk({tag, "_rk_out"}, rk_out, 128'h0);
    chk({tag, "_cached"}, cached, 1'b0);
  endtask

  task automatic start_key(input logic [127:0] k, input logic dec);
    model_expand(k);
    key_in = k;
    decrypt = dec;
    key_valid = 1'b1;
    push_stream(dec);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!rk_valid && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_wait_valid"}, rk_valid, 1'b1);
  endtask

  task automatic drain(input string tag, input bit rnd);
    int n;
    n = 0;
    while (rk_valid && n < 400) begin
      rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    rk_ready = 1'b1;
    chk({tag, "_drained"}, rk_valid, 1'b0);
    chk({tag, "_all_delivered"}, 128'(q.size()), 128'd0);
    if (!rnd) chk({tag, "_valid_cycles"}, 128'(n), 128'd11);
  endtask

  initial begin
    int n;
    build_sbox();
    model_expand(K1);
    chk("model_rk0", sched[0], K1);
    chk("model_rk1", sched[1], RK1);
    chk("model_rk10", sched[10], RK10);
    model_expand(K2);
    chk("model_k2_rk10", sched[10], K2R10);

    tick();
    chk_reset_outs("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // replay with nothing cached must be ignored
    replay_valid = 1'b1;
    decrypt = 1'b1;
    tick();
    replay_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("replay_nocache_valid", rk_valid, 1'b0);
      chk("replay_nocache_ready", key_ready, 1'b1);
      tick();
    end

    // encrypt, FIPS-197 key, no backpressure
    rk_ready = 1'b1;
    start_key(K1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("enc_expand_valid", rk_valid, 1'b0);
      chk("enc_expand_key_ready", key_ready, 1'b0);
      tick();
    end
    chk("enc_first_valid", rk_valid, 1'b1);
    chk("enc_first_key", rk_out, K1);
    n = 0;
    while (rk_valid && n < 20) begin
      if (n == 1) chk("enc_rk1", rk_out, RK1);
      if (n == 10) begin
        chk("enc_rk10", rk_out, RK10);
        chk("enc_rk10_last", rk_last, 1'b1);
      end
      n++;
      tick();
    end
    chk("enc_valid_cycles", 128'(n), 128'd11);
    chk("enc_cached", cached, 1'b1);
    chk("enc_back_idle", key_ready, 1'b1);

    // decrypt, same key
    start_key(K1, 1'b1);
    wait_valid("dec");
    n = 0;
    while (rk_valid && n < 20) begin
      if (n == 0) begin
        chk("dec_first_key", rk_out, RK10);
        chk("dec_first_idx", rk_index, 4'd10);
      end
      if (n == 10) begin
        chk("dec_last_key", rk_out, K1);
        chk("dec_last_idx", rk_index, 4'd0);
        chk("dec_last_flag", rk_last, 1'b1);
      end
      n++;
      tick();
    end
    chk("dec_valid_cycles", 128'(n), 128'd11);

    // encrypt with random backpressure
    start_key(K1, 1'b0);
    wait_valid("bp");
    drain("bp", 1'b1);

    // replay cached schedule in reverse order
    chk("replay_cached_pre", cached, 1'b1);
    replay_valid = 1'b1;
    decrypt = 1'b1;
    push_stream(1'b1);
    tick();
    replay_valid = 1'b0;
    chk("replay_immediate_valid", rk_valid, 1'b1);
    chk("replay_key_ready", key_ready, 1'b0);
    chk("replay_first_idx", rk_index, 4'd10);
    drain("replay", 1'b0);

    // key and replay together: key wins
    model_expand(K2);
    key_in = K2;
    decrypt = 1'b0;
    key_valid = 1'b1;
    replay_valid = 1'b1;
    push_stream(1'b0);
    tick();
    key_valid = 1'b0;
    replay_valid = 1'b0;
    chk("both_cached_drop", cached, 1'b0);
    chk("both_in_expand", rk_valid, 1'b0);
    chk("both_key_ready", key_ready, 1'b0);
    wait_valid("both");
    drain("both", 1'b0);

    // reset in the middle of expansion (cnt = 5)
    start_key(K1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    #1;
    reset_n = 1'b0;
    q.delete();
    #1;
    chk_reset_outs("rst_expand");
    tick();
    reset_n = 1'b1;
    tick();

    // reset in the middle of streaming (ptr = 3)
    start_key(K1, 1'b0);
    wait_valid("rs");
    n = 0;
    while (!(rk_valid && rk_index == 4'd3) && n < 20) begin
      tick();
      n++;
    end
    chk("rst_stream_reached_idx3", rk_index, 4'd3);
    chk("rst_stream_cached_pre", cached, 1'b1);
    #1;
    reset_n = 1'b0;
    q.delete();
    #1;
    chk_reset_outs("rst_stream");
    tick();
    reset_n = 1'b1;
    tick();

    // fresh key after reset, decrypt order
    start_key(K2, 1'b1);
    wait_valid("post");
    chk("post_first_key", rk_out, K2R10);
    drain("post", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
